// File: rtl/spm_pkg.sv
// Shared definitions for the SPM sharing controller: FSM state encoding,
// default operand width and the nominal latency of the SPM core.
// Purpose: common types/constants. Latency: n/a. Backpressure: n/a.
package spm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   localparam int W_DEF   = 32;
   // Cycles from start to done of the serial-parallel multiplier core.
   localparam int SPM_LAT = 66;

endpackage

// File: rtl/spm_share_ctrl_if.sv
// Bundle of requester, response and SPM-side signals of spm_share_ctrl.
// Purpose: port grouping. Latency: n/a. Backpressure: req and rsp valid/ready.
// Ports: req_* (per-requester operands/handshake), rsp_* (tagged result),
//        mul_* (SPM core control/data), busy.
// slave = the controller, master = the surrounding environment.
interface spm_share_ctrl_if
   import spm_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = W_DEF
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_mp;
   logic [NREQ*W-1:0] req_mc;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [2*W-1:0]    rsp_p;
   logic              rsp_err;
   logic              mul_start;
   logic [W-1:0]      mul_mp;
   logic [W-1:0]      mul_mc;
   logic              mul_done;
   logic [2*W-1:0]    mul_p;
   logic              busy;

   modport slave (
      input  req_valid, req_mp, req_mc, rsp_ready, mul_done, mul_p,
      output req_ready, rsp_valid, rsp_id, rsp_p, rsp_err,
             mul_start, mul_mp, mul_mc, busy
   );

   modport master (
      output req_valid, req_mp, req_mc, rsp_ready, mul_done, mul_p,
      input  req_ready, rsp_valid, rsp_id, rsp_p, rsp_err,
             mul_start, mul_mp, mul_mc, busy
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request bit at or above ptr, wrapping.
// Latency: purely combinational. Backpressure: none (caller qualifies grant).
// Ports: req (pending vector), ptr (search start) -> gnt (one-hot), idx, any.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] idx,
   output logic                    any
);

   // (p + k) mod NREQ for p < NREQ and k < NREQ, without a divider.
   function automatic logic [$clog2(NREQ)-1:0] cand(input logic [$clog2(NREQ)-1:0] p,
                                                    input int k);
      int s;
      s = int'(p) + k;
      if (s >= NREQ) s = s - NREQ;
      return s[$clog2(NREQ)-1:0];
   endfunction

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!any && req[cand(ptr, k)]) begin
            any = 1'b1;
            idx = cand(ptr, k);
         end
      end
      if (any) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/spm_share_ctrl.sv
// Shares one signed SPM core among NREQ requesters: round-robin grant, one-cycle
// start, done wait with watchdog, tagged 2W-bit result.
// Latency: grant T, mul_start T+1, rsp_valid T+3+k (k = WAIT entry to armed done).
// Backpressure: rsp held in RESP until rsp_ready; no grant outside IDLE.
// Ports: clk, rst (async, active-high), bus (spm_share_ctrl_if.slave).
module spm_share_ctrl
   import spm_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int W       = W_DEF,
   // Margin over the nominal SPM latency before declaring the core hung.
   parameter int TIMEOUT = SPM_LAT + 14
) (
   input  logic            clk,
   input  logic            rst,
   spm_share_ctrl_if.slave bus
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(TIMEOUT);

   state_t         state_q,     state_d;
   logic [W-1:0]   mul_mp_q,    mul_mp_d;
   logic [W-1:0]   mul_mc_q,    mul_mc_d;
   logic [IDW-1:0] rsp_id_q,    rsp_id_d;
   logic [IDW-1:0] rr_ptr_q,    rr_ptr_d;
   logic [2*W-1:0] rsp_p_q,     rsp_p_d;
   logic           rsp_err_q,   rsp_err_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic           mul_start_q, mul_start_d;
   logic           busy_q,      busy_d;
   logic           armed_q,     armed_d;
   logic [CW-1:0]  wd_cnt_q,    wd_cnt_d;

   logic [NREQ-1:0] arb_gnt;
   logic [IDW-1:0]  arb_idx;
   logic            arb_any;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req (bus.req_valid),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   // Acceptance is only offered while idle; the pulse lasts the grant cycle.
   assign bus.req_ready = (state_q == ST_IDLE) ? arb_gnt : '0;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_p     = rsp_p_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.mul_start = mul_start_q;
   assign bus.mul_mp    = mul_mp_q;
   assign bus.mul_mc    = mul_mc_q;
   assign bus.busy      = busy_q;

   always_comb begin
      state_d     = state_q;
      mul_mp_d    = mul_mp_q;
      mul_mc_d    = mul_mc_q;
      rsp_id_d    = rsp_id_q;
      rr_ptr_d    = rr_ptr_q;
      rsp_p_d     = rsp_p_q;
      rsp_err_d   = rsp_err_q;
      armed_d     = armed_q;
      wd_cnt_d    = wd_cnt_q;
      mul_start_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               mul_mp_d    = bus.req_mp[int'(arb_idx)*W +: W];
               mul_mc_d    = bus.req_mc[int'(arb_idx)*W +: W];
               rsp_id_d    = arb_idx;
               mul_start_d = 1'b1;
               state_d     = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            wd_cnt_d = '0;
            armed_d  = 1'b0;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            wd_cnt_d = wd_cnt_q + 1'b1;
            // done may still be high from the previous product; only a done
            // that follows an observed low level belongs to this operation.
            armed_d  = armed_q | ~bus.mul_done;
            if (armed_q && bus.mul_done) begin
               rsp_p_d   = bus.mul_p;
               rsp_err_d = 1'b0;
               state_d   = ST_RESP;
            end else if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
               rsp_p_d   = '0;
               rsp_err_d = 1'b1;
               state_d   = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               rr_ptr_d = (rsp_id_q == IDW'(NREQ - 1)) ? '0 : rsp_id_q + 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Registered status outputs follow the state being entered.
      rsp_valid_d = (state_d == ST_RESP);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mul_mp_q    <= '0;
         mul_mc_q    <= '0;
         rsp_id_q    <= '0;
         rr_ptr_q    <= '0;
         rsp_p_q     <= '0;
         rsp_err_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         mul_start_q <= 1'b0;
         busy_q      <= 1'b0;
         armed_q     <= 1'b0;
         wd_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         mul_mp_q    <= mul_mp_d;
         mul_mc_q    <= mul_mc_d;
         rsp_id_q    <= rsp_id_d;
         rr_ptr_q    <= rr_ptr_d;
         rsp_p_q     <= rsp_p_d;
         rsp_err_q   <= rsp_err_d;
         rsp_valid_q <= rsp_valid_d;
         mul_start_q <= mul_start_d;
         busy_q      <= busy_d;
         armed_q     <= armed_d;
         wd_cnt_q    <= wd_cnt_d;
      end
   end

endmodule

// File: tb/tb_spm_share_ctrl.sv
// Bench for spm_share_ctrl: SPM behavioural core plus a round-robin/product
// reference model; directed scenarios followed by randomized traffic.
module tb_spm_share_ctrl;
   import spm_pkg::*;

   localparam int NREQ    = 4;
   localparam int W       = 32;
   localparam int TIMEOUT = 80;
   localparam int IDW     = $clog2(NREQ);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spm_share_ctrl_if #(.NREQ(NREQ), .W(W)) bus ();

   spm_share_ctrl #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int mdl_ptr = 0;
   logic [W-1:0] op_mp [NREQ];
   logic [W-1:0] op_mc [NREQ];

   // ---------------- SPM core model ----------------
   int   stale_cfg = 0;      // cycles the old done stays high after start
   bit   hang = 1'b0;        // core never raises done
   logic spm_done = 1'b0;
   logic [2*W-1:0] spm_p = '0;
   logic [W-1:0] spm_a = '0;
   logic [W-1:0] spm_b = '0;
   int   spm_cnt = 0;
   int   spm_hold = 0;

   assign bus.mul_done = spm_done;
   assign bus.mul_p    = spm_p;

   always @(posedge clk) begin
      if (bus.mul_start === 1'b1) begin
         spm_a    <= bus.mul_mp;
         spm_b    <= bus.mul_mc;
         spm_cnt  <= SPM_LAT;
         spm_hold <= stale_cfg;
         if (stale_cfg == 0) spm_done <= 1'b0;
      end else if (spm_hold > 0) begin
         spm_hold <= spm_hold - 1;
         if (spm_hold == 1) spm_done <= 1'b0;
      end else if (spm_cnt > 0) begin
         spm_cnt <= spm_cnt - 1;
         if (spm_cnt == 1 && !hang) begin
            spm_done <= 1'b1;
            spm_p    <= 64'(longint'($signed(spm_a)) * longint'($signed(spm_b)));
         end
      end
   end

   // ---------------- reference helpers ----------------
   function automatic int rr_pick(input logic [NREQ-1:0] pend, input int ptr);
      for (int k = 0; k < NREQ; k++)
         if (pend[(ptr + k) % NREQ] === 1'b1) return (ptr + k) % NREQ;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_req_ready"}, 64'(bus.req_ready), 0);
      chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 0);
      chk({tag, "_rsp_id"},    64'(bus.rsp_id),    0);
      chk({tag, "_rsp_p"},     bus.rsp_p,          0);
      chk({tag, "_rsp_err"},   64'(bus.rsp_err),   0);
      chk({tag, "_mul_start"}, 64'(bus.mul_start), 0);
      chk({tag, "_mul_mp"},    64'(bus.mul_mp),    0);
      chk({tag, "_mul_mc"},    64'(bus.mul_mc),    0);
      chk({tag, "_busy"},      64'(bus.busy),      0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1 chk_reset_outs("rst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mdl_ptr = 0;
   endtask

   task automatic set_req(input int i, input logic [W-1:0] mp, input logic [W-1:0] mc);
      op_mp[i] = mp;
      op_mc[i] = mc;
      bus.req_mp[i*W +: W] = mp;
      bus.req_mc[i*W +: W] = mc;
      bus.req_valid[i] = 1'b1;
   endtask

   // One complete operation: grant, launch, wait, response, handshake.
   // gid returns the requester id reported by the DUT on the response.
   task automatic do_op(input bit keep_valid, input int hold, input bit exp_err,
                        input int exp_lat, output int gid);
      int n, e, stray, bad;
      logic [63:0] expp;
      bus.rsp_ready = (hold == 0);
      #1;
      n = 0;
      while (bus.req_ready === '0 && n < 300) begin
         @(negedge clk); #1; n++;
      end
      chk("grant_seen", 64'(bus.req_ready !== '0), 1);
      e = rr_pick(bus.req_valid, mdl_ptr);
      if (e < 0) e = 0;
      chk("grant_onehot", 64'(bus.req_ready), 64'(1) << e);
      expp = exp_err ? 64'(0) : 64'(longint'($signed(op_mp[e])) * longint'($signed(op_mc[e])));
      @(negedge clk); #1;
      if (!keep_valid) bus.req_valid[e] = 1'b0;
      chk("ready_pulse", 64'(bus.req_ready), 0);
      chk("launch_start", 64'(bus.mul_start), 1);
      chk("launch_busy", 64'(bus.busy), 1);
      chk("mul_mp", 64'(bus.mul_mp), 64'(op_mp[e]));
      chk("mul_mc", 64'(bus.mul_mc), 64'(op_mc[e]));
      n = 1;
      stray = 0;
      while (bus.rsp_valid !== 1'b1 && n < 300) begin
         @(negedge clk); #1; n++;
         if (bus.mul_start !== 1'b0 || bus.req_ready !== '0) stray++;
      end
      chk("rsp_latency", 64'(n), 64'(exp_lat));
      chk("stray_start_or_ready", 64'(stray), 0);
      chk("rsp_id", 64'(bus.rsp_id), 64'(e));
      chk("rsp_p", bus.rsp_p, expp);
      chk("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
      gid = int'(bus.rsp_id);
      if (hold > 0) begin
         bad = 0;
         for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(e) || bus.rsp_p !== expp ||
                bus.rsp_err !== exp_err || bus.req_ready !== '0 || bus.mul_start !== 1'b0)
               bad++;
         end
         chk("hold_stable", 64'(bad), 0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk); #1;
      chk("rsp_valid_drop", 64'(bus.rsp_valid), 0);
      chk("busy_idle", 64'(bus.busy), 0);
      mdl_ptr = (e + 1) % NREQ;
   endtask

   int rr_exp [5] = '{0, 1, 2, 3, 0};
   int gid, g1, g2, d, bad, n;

   initial begin
      bus.req_valid = '0;
      bus.req_mp    = '0;
      bus.req_mc    = '0;
      bus.rsp_ready = 1'b0;
      do_reset();

      // 1: single multiply, 3 * -5
      set_req(0, 32'd3, -32'sd5);
      do_op(1'b0, 0, 1'b0, 3 + SPM_LAT, gid);
      chk("t1_id", 64'(gid), 0);

      // 2: round-robin with all requesters continuously valid
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, W'(i + 2), W'(-(i + 1)));
      for (int k = 0; k < 5; k++) begin
         do_op(1'b1, 0, 1'b0, 3 + SPM_LAT, gid);
         chk("rr_order", 64'(gid), 64'(rr_exp[k]));
      end
      bus.req_valid = '0;

      // 3: previous done still high for two cycles after start
      stale_cfg = 2;
      set_req(int'($urandom_range(0, NREQ - 1)), $urandom, $urandom);
      do_op(1'b0, 0, 1'b0, 5 + SPM_LAT, gid);
      stale_cfg = 0;

      // 4: watchdog abort, then a normal operation
      hang = 1'b1;
      set_req(int'($urandom_range(0, NREQ - 1)), $urandom, $urandom);
      do_op(1'b0, 0, 1'b1, TIMEOUT + 2, gid);
      hang = 1'b0;
      set_req(int'($urandom_range(0, NREQ - 1)), $urandom, $urandom);
      do_op(1'b0, 0, 1'b0, 3 + SPM_LAT, gid);

      // 5: response backpressure while requesters 1 and 2 wait
      set_req(1, $urandom, $urandom);
      set_req(2, $urandom, $urandom);
      do_op(1'b0, 20, 1'b0, 3 + SPM_LAT, g1);
      do_op(1'b0, 0, 1'b0, 3 + SPM_LAT, g2);
      chk("bp_both_served", (64'(1) << g1) | (64'(1) << g2), 64'h6);

      // randomized traffic
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < NREQ; i++)
            if (bus.req_valid[i] === 1'b0 && $urandom_range(0, 1) == 1)
               set_req(i, $urandom, $urandom);
         #1;
         if ($urandom_range(0, 3) == 0) begin
            d = int'($urandom_range(0, NREQ - 1));
            if (bus.req_ready[d] === 1'b0 && $countones(bus.req_valid) > 1)
               bus.req_valid[d] = 1'b0;
         end
         if (bus.req_valid === '0) set_req(int'($urandom_range(0, NREQ - 1)), $urandom, $urandom);
         do_op(1'b0, int'($urandom_range(0, 3)), 1'b0, 3 + SPM_LAT, gid);
      end
      for (int k = 0; k < NREQ && bus.req_valid !== '0; k++)
         do_op(1'b0, 0, 1'b0, 3 + SPM_LAT, gid);

      // 6: asynchronous reset 30 cycles into WAIT
      bus.rsp_ready = 1'b1;
      set_req(0, $urandom, $urandom);
      #1;
      n = 0;
      while (bus.req_ready === '0 && n < 10) begin
         @(negedge clk); #1; n++;
      end
      chk("t6_grant", 64'(bus.req_ready), 64'h1);
      @(negedge clk); #1;
      bus.req_valid = '0;
      repeat (31) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_reset_outs("wait_rst");
      @(negedge clk);
      rst = 1'b0;
      mdl_ptr = 0;
      bad = 0;
      repeat (80) begin
         @(negedge clk); #1;
         if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.mul_start !== 1'b0) bad++;
      end
      chk("no_rsp_after_rst", 64'(bad), 0);
      set_req(3, $urandom, $urandom);
      do_op(1'b0, 0, 1'b0, 3 + SPM_LAT, gid);
      chk("t6_first_id", 64'(gid), 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spm_share_ctrl.md
Name: spm_share_ctrl

Overview:
Arbitration and sequencing controller that shares one 32-bit signed serial-parallel multiplier (SPM) core among NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and selects one requester by round-robin. It launches the SPM with a one-cycle start pulse, holds the operands stable, and waits for done (with a watchdog). It then returns the 64-bit product tagged with the requester ID. It sits between the client blocks and the SPM instance.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 32, operand width; product is 2*W
TIMEOUT, 80, max cycles in WAIT before abort (must exceed SPM latency, nominally 66)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NREQ  request pending, per requester
req_ready  out  NREQ  one-hot acceptance pulse
req_mp  in  NREQ*W  multiplier operands, requester i at bits [i*W +: W]
req_mc  in  NREQ*W  multiplicand operands, same packing
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  clog2(NREQ)  requester index of result
rsp_p  out  2*W  signed product
rsp_err  out  1  1 = watchdog abort, rsp_p = 0
mul_start  out  1  one-cycle start pulse to SPM
mul_mp  out  W  operand to SPM, held stable from LAUNCH to end of WAIT
mul_mc  out  W  operand to SPM, same hold rule
mul_done  in  1  SPM done (level)
mul_p  in  2*W  SPM product
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values, asynchronous: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_p=0, rsp_err=0, mul_start=0, mul_mp=0, mul_mc=0, busy=0, rr pointer=0, wd counter=0.
- Reset mid-operation aborts silently. No response is produced, and the SPM is left to finish; its done is ignored.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE, with any req_valid set:
  - Grant the first set bit searching upward from rr pointer, wrapping modulo NREQ.
  - Same cycle: req_ready[g]=1 (combinational from state/valid/pointer). Latch mp/mc into mul_mp/mul_mc, latch g into rsp_id.
  - Next state LAUNCH.
- LAUNCH: mul_start=1 for exactly one cycle. Clear the wd counter and the armed flag. Next state WAIT.
- WAIT:
  - wd counter increments each cycle.
  - armed is set when mul_done is observed low. This masks the stale done from the previous operation.
  - armed && mul_done: rsp_p <= mul_p, rsp_err <= 0, next state RESP.
  - Counter reaching TIMEOUT-1 without capture: rsp_p <= 0, rsp_err <= 1, next state RESP.
  - If capture and timeout occur in the same cycle, capture wins.
- RESP:
  - rsp_valid=1. rsp_id, rsp_p and rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: rr pointer <= (g+1) mod NREQ, next state IDLE.
- Requester rules:
  - A requester holds req_valid and its operands stable until its req_ready.
  - A requester deasserting valid before grant is legal and causes no error.
- No pipelining: one outstanding operation. Arbitration occurs only in IDLE, so there is a one-cycle bubble after each response.
- Latency: grant at cycle T, mul_start at T+1, rsp_valid at T+3+k, where k = cycles from WAIT entry to first armed done.
- Fairness: a continuously requesting requester is granted within NREQ operations.
- mul_mp/mul_mc change only in the IDLE grant cycle.
- rsp_p is passed through unchanged (signed, 2*W bits). The controller performs no arithmetic on it.

Decomposition:
- Shared package spm_pkg: FSM state encoding (IDLE=0, LAUNCH=1, WAIT=2, RESP=3), default W=32, SPM nominal latency constant SPM_LAT=66.
- One sub-module: rr_arbiter, parameterised NREQ.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, encoded index, any.
  - Purely combinational.
- The FSM, watchdog and datapath registers stay in spm_share_ctrl.

Test Plan:
1. Single multiply: requester 0, mp=3, mc=-5; bench SPM model with 66-cycle latency -> exactly one mul_start pulse; rsp_valid with rsp_id=0, rsp_p=64'hFFFF_FFFF_FFFF_FFF1, rsp_err=0; busy back to 0 one cycle after rsp_ready.
2. Round-robin: all 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0. Products match (i+2)*(-(i+1)). Each req_ready is a one-cycle pulse.
3. Stale done: SPM model holds done=1 from the previous operation for 2 cycles after start -> no early capture; capture occurs only after done goes low, then high.
4. Watchdog: SPM model never asserts done -> after TIMEOUT=80 WAIT cycles, rsp_err=1 and rsp_p=0. The next request is served normally.
5. Backpressure: rsp_ready held low 20 cycles while requesters 1 and 2 wait -> rsp fields stable; no req_ready and no mul_start until the handshake completes.
6. Async reset in WAIT, cycle 30 -> all outputs 0 immediately; no rsp_valid. The post-reset request from requester 3 is granted first with pointer=0.
